// File: rtl/ptx_decode_stage_pkg.sv
// ptx_pkg: shared types for the PTX decode stage.
//  - fu_e          functional-unit selector carried in every decoded bundle
//  - state_e       decode-stage FSM state (exported for observation)
//  - OP_*          opcode map
//  - dec_bundle_t  fully decoded instruction bundle
// The bundle struct is sized from the package widths below; the top-level
// parameters default to the same values and must be kept in step with them.
package ptx_pkg;

  localparam int PTX_INST_W = 32;
  localparam int PTX_REG_W  = 5;
  localparam int PTX_DATA_W = 32;
  localparam int PTX_WARP_W = 5;
  localparam int PTX_CNT_W  = 32;

  typedef enum logic [2:0] {
    FU_NONE   = 3'd0,
    FU_ALU    = 3'd1,
    FU_FPU    = 3'd2,
    FU_LSU    = 3'd3,
    FU_SFU    = 3'd4,
    FU_BRANCH = 3'd5
  } fu_e;

  typedef enum logic [0:0] {
    ST_IDLE     = 1'b0,
    ST_WAIT_EXT = 1'b1
  } state_e;

  localparam logic [5:0] OP_ADD    = 6'h00;
  localparam logic [5:0] OP_ADDI   = 6'h01;
  localparam logic [5:0] OP_FADD   = 6'h02;
  localparam logic [5:0] OP_FMUL   = 6'h03;
  localparam logic [5:0] OP_LD     = 6'h04;
  localparam logic [5:0] OP_ST     = 6'h05;
  localparam logic [5:0] OP_BRA    = 6'h06;
  localparam logic [5:0] OP_RSQRT  = 6'h07;
  localparam logic [5:0] OP_VADD   = 6'h08;
  localparam logic [5:0] OP_VFMUL  = 6'h09;
  localparam logic [5:0] OP_MOVI32 = 6'h0A;

  typedef struct packed {
    logic [PTX_WARP_W-1:0] warp;
    logic [5:0]            opcode;
    logic [PTX_REG_W-1:0]  rd;
    logic [PTX_REG_W-1:0]  rs1;
    logic [PTX_REG_W-1:0]  rs2;
    logic [PTX_DATA_W-1:0] imm;
    fu_e                   fu;
    logic                  use_imm;
    logic                  vector;
    logic                  illegal;
  } dec_bundle_t;

endpackage

// File: rtl/ptx_decode_stage_field_decode.sv
// ptx_field_decode: purely combinational fetch word -> dec_bundle_t.
// Ports:
//  instr   in   fetch word ([31:26] op, [25:21] rd, [20:16] rs1, [15:11] rs2, [15:0] imm)
//  warp    in   warp id copied into the bundle
//  bundle  out  decoded fields, functional unit, flags, sign-extended immediate
// Unknown opcodes decode to illegal with fu NONE and both flags cleared.
module ptx_field_decode
  import ptx_pkg::*;
(
  input  logic [PTX_INST_W-1:0] instr,
  input  logic [PTX_WARP_W-1:0] warp,
  output dec_bundle_t           bundle
);

  always_comb begin
    bundle         = '0;
    bundle.fu      = FU_NONE;
    bundle.warp    = warp;
    bundle.opcode  = instr[31:26];
    bundle.rd      = instr[25:21];
    bundle.rs1     = instr[20:16];
    bundle.rs2     = instr[15:11];
    bundle.imm     = {{(PTX_DATA_W-16){instr[15]}}, instr[15:0]};
    case (instr[31:26])
      OP_ADD:    bundle.fu = FU_ALU;
      OP_ADDI:   begin bundle.fu = FU_ALU;    bundle.use_imm = 1'b1; end
      OP_FADD:   bundle.fu = FU_FPU;
      OP_FMUL:   bundle.fu = FU_FPU;
      OP_LD:     begin bundle.fu = FU_LSU;    bundle.use_imm = 1'b1; end
      OP_ST:     begin bundle.fu = FU_LSU;    bundle.use_imm = 1'b1; end
      OP_BRA:    begin bundle.fu = FU_BRANCH; bundle.use_imm = 1'b1; end
      OP_RSQRT:  bundle.fu = FU_SFU;
      OP_VADD:   begin bundle.fu = FU_ALU;    bundle.vector  = 1'b1; end
      OP_VFMUL:  begin bundle.fu = FU_FPU;    bundle.vector  = 1'b1; end
      OP_MOVI32: begin bundle.fu = FU_ALU;    bundle.use_imm = 1'b1; end
      default:   bundle.illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/ptx_decode_stage.sv
// ptx_decode_stage: registered, flow-controlled PTX decode stage.
// Ports:
//  clk, rst_n            clock, asynchronous active-low reset
//  flush                 synchronous discard of pending and output state
//  in_valid/in_ready     fetch side handshake; in_instr, in_warp payload
//  out_valid/out_ready   issue side handshake; out_* decoded bundle
//  stat_decoded          saturating count of bundles transferred out
//  stat_illegal          saturating count of illegal bundles transferred out
//  state                 current FSM state, for observation
// Handshake: a word/bundle moves when valid && ready are both high at a rising
// edge. The output register accepts a new bundle whenever it is empty or being
// drained in the same cycle, giving one bundle per cycle. out_valid and the
// bundle hold until out_ready. in_ready is low during flush and during the
// cycle a WAIT_EXT stage sees a word from a foreign warp (it emits the broken
// movi32 as illegal instead; the word is taken on a later cycle).
module ptx_decode_stage
  import ptx_pkg::*;
#(
  parameter int INST_WIDTH = PTX_INST_W,
  parameter int REG_WIDTH  = PTX_REG_W,
  parameter int DATA_WIDTH = PTX_DATA_W,
  parameter int WARP_W     = PTX_WARP_W,
  parameter int CNT_W      = PTX_CNT_W
)(
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  flush,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [INST_WIDTH-1:0] in_instr,
  input  logic [WARP_W-1:0]     in_warp,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [WARP_W-1:0]     out_warp,
  output logic [5:0]            out_opcode,
  output logic [REG_WIDTH-1:0]  out_rd,
  output logic [REG_WIDTH-1:0]  out_rs1,
  output logic [REG_WIDTH-1:0]  out_rs2,
  output logic [DATA_WIDTH-1:0] out_imm,
  output fu_e                   out_fu,
  output logic                  out_use_imm,
  output logic                  out_vector,
  output logic                  out_illegal,
  output logic [CNT_W-1:0]      stat_decoded,
  output logic [CNT_W-1:0]      stat_illegal,
  output state_e                state
);

  state_e           state_q;
  dec_bundle_t      dec, pend_q, out_q, ext_bundle, broken_bundle;
  logic             out_valid_q;
  logic [CNT_W-1:0] dec_cnt_q, ill_cnt_q;
  logic             out_free, warp_mismatch, in_fire, out_xfer;

  ptx_field_decode u_field_decode (
    .instr  (in_instr),
    .warp   (in_warp),
    .bundle (dec)
  );

  always_comb begin
    out_free      = !flush && (!out_valid_q || out_ready);
    warp_mismatch = (state_q == ST_WAIT_EXT) && in_valid && (in_warp != pend_q.warp);
    in_ready      = out_free && !warp_mismatch;
    in_fire       = in_valid && in_ready;
    // A transfer coinciding with flush is discarded, so it is not counted.
    out_xfer      = out_valid_q && out_ready && !flush;

    // Second word of movi32 supplies the full immediate, zero-extended.
    ext_bundle     = pend_q;
    ext_bundle.imm = DATA_WIDTH'(in_instr);

    // A movi32 whose extension never arrives is reported and not dispatched.
    broken_bundle         = pend_q;
    broken_bundle.fu      = FU_NONE;
    broken_bundle.use_imm = 1'b0;
    broken_bundle.vector  = 1'b0;
    broken_bundle.illegal = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      out_valid_q <= 1'b0;
      out_q       <= '0;
      pend_q      <= '0;
      dec_cnt_q   <= '0;
      ill_cnt_q   <= '0;
    end else if (flush) begin
      state_q     <= ST_IDLE;
      out_valid_q <= 1'b0;
      pend_q      <= '0;
    end else begin
      if (out_xfer) begin
        out_valid_q <= 1'b0;
        if (dec_cnt_q != '1) dec_cnt_q <= dec_cnt_q + CNT_W'(1);
        if (out_q.illegal && (ill_cnt_q != '1)) ill_cnt_q <= ill_cnt_q + CNT_W'(1);
      end
      case (state_q)
        ST_IDLE: begin
          if (in_fire) begin
            if (dec.opcode == OP_MOVI32) begin
              pend_q  <= dec;
              state_q <= ST_WAIT_EXT;
            end else begin
              out_q       <= dec;
              out_valid_q <= 1'b1;
            end
          end
        end
        ST_WAIT_EXT: begin
          if (in_fire) begin
            out_q       <= ext_bundle;
            out_valid_q <= 1'b1;
            state_q     <= ST_IDLE;
          end else if (warp_mismatch && out_free) begin
            out_q       <= broken_bundle;
            out_valid_q <= 1'b1;
            state_q     <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign out_valid    = out_valid_q;
  assign out_warp     = out_q.warp;
  assign out_opcode   = out_q.opcode;
  assign out_rd       = out_q.rd;
  assign out_rs1      = out_q.rs1;
  assign out_rs2      = out_q.rs2;
  assign out_imm      = out_q.imm;
  assign out_fu       = out_q.fu;
  assign out_use_imm  = out_q.use_imm;
  assign out_vector   = out_q.vector;
  assign out_illegal  = out_q.illegal;
  assign stat_decoded = dec_cnt_q;
  assign stat_illegal = ill_cnt_q;
  assign state        = state_q;

endmodule

// File: tb/tb_ptx_decode_stage.sv
// Directed bench for ptx_decode_stage with a bundle scoreboard.
module tb_ptx_decode_stage;
  import ptx_pkg::*;

  logic        clk, rst_n, flush, in_valid, in_ready, out_valid, out_ready;
  logic [31:0] in_instr, out_imm, stat_decoded, stat_illegal;
  logic [4:0]  in_warp, out_warp, out_rd, out_rs1, out_rs2;
  logic [5:0]  out_opcode;
  logic        out_use_imm, out_vector, out_illegal;
  fu_e         out_fu;
  state_e      state;

  ptx_decode_stage dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr), .in_warp(in_warp),
    .out_valid(out_valid), .out_ready(out_ready), .out_warp(out_warp),
    .out_opcode(out_opcode), .out_rd(out_rd), .out_rs1(out_rs1), .out_rs2(out_rs2),
    .out_imm(out_imm), .out_fu(out_fu), .out_use_imm(out_use_imm),
    .out_vector(out_vector), .out_illegal(out_illegal),
    .stat_decoded(stat_decoded), .stat_illegal(stat_illegal), .state(state)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- bookkeeping ----------------
  int checks = 0;
  int failures = 0;
  int exp_dec = 0;
  int exp_ill = 0;
  logic [63:0] exp_q[$];

  localparam logic [2:0] F_NONE = 3'd0, F_ALU = 3'd1, F_FPU = 3'd2,
                         F_LSU = 3'd3, F_SFU = 3'd4, F_BRA = 3'd5;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
      $error("check %s", tag);
    end
  endtask

  function automatic logic [63:0] pack(input logic [4:0] w, input logic [5:0] op,
      input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
      input logic [31:0] imm, input logic [2:0] fu, input logic ui,
      input logic vec, input logic ill);
    return {w, op, rd, rs1, rs2, imm, fu, ui, vec, ill};
  endfunction

  // Reference decode of a single word.
  function automatic logic [63:0] model(input logic [4:0] w, input logic [31:0] ins);
    logic [5:0]  op;
    logic [31:0] sx;
    logic [2:0]  fu;
    logic        ui, vec, ill;
    op = ins[31:26];
    sx = {{16{ins[15]}}, ins[15:0]};
    fu = F_NONE; ui = 1'b0; vec = 1'b0; ill = 1'b0;
    case (op)
      6'h00: fu = F_ALU;
      6'h01: begin fu = F_ALU; ui = 1'b1; end
      6'h02, 6'h03: fu = F_FPU;
      6'h04, 6'h05: begin fu = F_LSU; ui = 1'b1; end
      6'h06: begin fu = F_BRA; ui = 1'b1; end
      6'h07: fu = F_SFU;
      6'h08: begin fu = F_ALU; vec = 1'b1; end
      6'h09: begin fu = F_FPU; vec = 1'b1; end
      6'h0A: begin fu = F_ALU; ui = 1'b1; end
      default: ill = 1'b1;
    endcase
    return pack(w, op, ins[25:21], ins[20:16], ins[15:11], sx, fu, ui, vec, ill);
  endfunction

  function automatic logic [63:0] observed();
    return {out_warp, out_opcode, out_rd, out_rs1, out_rs2, out_imm, out_fu,
            out_use_imm, out_vector, out_illegal};
  endfunction

  function automatic logic [31:0] mk(input logic [5:0] op, input logic [4:0] rd,
      input logic [4:0] rs1, input logic [15:0] imm);
    return {op, rd, rs1, imm};
  endfunction

  task automatic push(input logic [63:0] b);
    exp_q.push_back(b);
    exp_dec++;
    if (b[0]) exp_ill++;
  endtask

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present a word until accepted; waits = cycles with in_ready low.
  task automatic send(input logic [4:0] w, input logic [31:0] ins, output int waits);
    waits = 0;
    in_valid = 1'b1; in_warp = w; in_instr = ins;
    #1;
    while (!in_ready && waits < 50) begin
      step();
      waits++;
    end
    if (waits >= 50) check("send_timeout", 64'(waits), 64'(0));
    step();
    in_valid = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_out_valid"}, 64'(out_valid), 64'(0));
    check({tag, "_bundle"}, observed(), 64'(0));
    check({tag, "_state"}, 64'(state), 64'(ST_IDLE));
    check({tag, "_stats"}, {stat_decoded, stat_illegal}, 64'(0));
  endtask

  // ---------------- scoreboard ----------------
  always @(negedge clk) begin
    if (rst_n && !flush && out_valid && out_ready) begin
      if (exp_q.size() == 0) check("unexpected_bundle", observed(), 64'(0));
      else check("bundle", observed(), exp_q.pop_front());
    end
  end

  initial begin
    #500000;
    $display("FAIL global_timeout");
    $fatal(1, "timeout");
  end

  // ---------------- directed sequence ----------------
  initial begin
    int w;
    logic [31:0] ins, movi;
    logic [63:0] b;
    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; in_instr = '0; in_warp = '0;
    out_ready = 1'b1;
    #1;
    check_reset_outputs("reset");
    repeat (2) step();
    rst_n = 1'b1;
    step();

    // addi warp3 rd=2 rs1=1 imm=0xFFF0
    ins = mk(6'h01, 5'd2, 5'd1, 16'hFFF0);
    push(pack(5'd3, 6'h01, 5'd2, 5'd1, 5'd31, 32'hFFFF_FFF0, F_ALU, 1'b1, 1'b0, 1'b0));
    send(5'd3, ins, w);
    check("addi_latency", 64'(out_valid), 64'(1));
    step(); step();

    // movi32 warp5 + extension warp5
    movi = mk(6'h0A, 5'd7, 5'd0, 16'h1234);
    send(5'd5, movi, w);
    check("movi_no_bundle", 64'(out_valid), 64'(0));
    check("movi_wait_state", 64'(state), 64'(ST_WAIT_EXT));
    b = model(5'd5, movi);
    b[37:6] = 32'hDEAD_BEEF;
    push(b);
    send(5'd5, 32'hDEAD_BEEF, w);
    step();
    check("movi_stat_decoded", 64'(stat_decoded), 64'(2));

    // movi32 warp5 followed by add warp6: broken pair
    movi = mk(6'h0A, 5'd9, 5'd3, 16'h8001);
    send(5'd5, movi, w);
    b = model(5'd5, movi);
    b[5:0] = {F_NONE, 1'b0, 1'b0, 1'b1};
    push(b);
    ins = mk(6'h00, 5'd3, 5'd4, 16'h2800);
    push(model(5'd6, ins));
    send(5'd6, ins, w);
    check("broken_in_ready_low_once", 64'(w), 64'(1));
    step();
    check("broken_stat_illegal", 64'(stat_illegal), 64'(1));
    check("broken_stat_decoded", 64'(stat_decoded), 64'(4));

    // back-pressure: bundle held, input blocked
    out_ready = 1'b0;
    ins = mk(6'h08, 5'd1, 5'd2, 16'h1800);
    b = model(5'd1, ins);
    push(b);
    send(5'd1, ins, w);
    in_valid = 1'b1; in_warp = 5'd2; in_instr = mk(6'h02, 5'd4, 5'd5, 16'h3000);
    for (int i = 0; i < 4; i++) begin
      check("stall_in_ready", 64'(in_ready), 64'(0));
      check("stall_bundle_stable", observed(), b);
      step();
    end
    push(model(5'd2, in_instr));
    out_ready = 1'b1;
    send(5'd2, in_instr, w);
    check("stall_resume", 64'(w), 64'(0));

    // full-throughput random single-word stream (0x0B exercises illegal)
    for (int i = 0; i < 6; i++) begin
      logic [5:0] op;
      logic [4:0] wr;
      op = 6'($urandom_range(0, 11));
      if (op == 6'h0A) op = 6'h0B;
      wr = 5'($urandom_range(0, 31));
      ins = {op, 5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)), 16'($urandom_range(0, 65535))};
      push(model(wr, ins));
      send(wr, ins, w);
      check("throughput_no_wait", 64'(w), 64'(0));
    end
    step(); step();
    check("stream_stat_decoded", 64'(stat_decoded), 64'(exp_dec));
    check("stream_stat_illegal", 64'(stat_illegal), 64'(exp_ill));

    // opcode 0x3F
    ins = mk(6'h3F, 5'd1, 5'd1, 16'h0001);
    push(pack(5'd4, 6'h3F, 5'd1, 5'd1, 5'd0, 32'h1, F_NONE, 1'b0, 1'b0, 1'b1));
    send(5'd4, ins, w);
    step();

    // flush with a held bundle
    out_ready = 1'b0;
    send(5'd7, mk(6'h04, 5'd2, 5'd3, 16'h0010), w);
    flush = 1'b1; out_ready = 1'b1;
    in_valid = 1'b1; in_warp = 5'd7; in_instr = mk(6'h00, 5'd1, 5'd1, 16'h0);
    #1;
    check("flush_in_ready", 64'(in_ready), 64'(0));
    step();
    flush = 1'b0; in_valid = 1'b0;
    check("flush_out_valid", 64'(out_valid), 64'(0));
    check("flush_stats", {stat_decoded, stat_illegal}, {32'(exp_dec), 32'(exp_ill)});

    // flush while waiting for an extension discards the pending movi32
    send(5'd3, mk(6'h0A, 5'd1, 5'd1, 16'h7777), w);
    flush = 1'b1;
    step();
    flush = 1'b0;
    check("flush_wait_state", 64'(state), 64'(ST_IDLE));
    ins = mk(6'h07, 5'd8, 5'd9, 16'h5000);
    push(model(5'd3, ins));
    send(5'd3, ins, w);
    step(); step();
    check("queue_drained", 64'(exp_q.size()), 64'(0));

    // reset while in WAIT_EXT
    send(5'd2, mk(6'h0A, 5'd1, 5'd1, 16'h0), w);
    rst_n = 1'b0;
    #1;
    check_reset_outputs("reset_wait");
    exp_dec = 0; exp_ill = 0;
    step();
    rst_n = 1'b1;

    // reset while a bundle is held
    out_ready = 1'b0;
    send(5'd1, mk(6'h00, 5'd1, 5'd2, 16'h0), w);
    rst_n = 1'b0;
    #1;
    check_reset_outputs("reset_held");
    step();
    rst_n = 1'b1;
    out_ready = 1'b1;
    ins = mk(6'h00, 5'd5, 5'd6, 16'h3800);
    push(model(5'd2, ins));
    send(5'd2, ins, w);
    step(); step();
    check("post_reset_stat", 64'(stat_decoded), 64'(exp_dec));
    check("final_queue_empty", 64'(exp_q.size()), 64'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
